// File: rtl/gpu_ib_pkg.sv
// Shared types for the per-warp instruction buffer: the decoded-entry layout
// carried on the Decode -> I-buffer -> Issue path, warp count and ALU opcodes.
package gpu_ib_pkg;

  localparam int NUM_WARPS = 8;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8;

  typedef struct packed {
    logic [31:0] Inst;
    logic [4:0]  Src1;
    logic [4:0]  Src2;
    logic [4:0]  Dst;
    logic [15:0] Imme;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        Exit;
    logic [3:0]  ALUop;
    logic        Shared_Globalbar;
    logic        Src1_Valid;
    logic        Src2_Valid;
    logic        Imme_Valid;
    logic        BEQ;
    logic        BLT;
  } ib_entry_t;

  localparam int ENTRY_W = $bits(ib_entry_t);

endpackage

// File: rtl/ibuf_warp_fifo.sv
// In-order FIFO holding one warp's decoded instructions. The caller qualifies
// enq against the space rule; flush clears pointers and count immediately.
module ibuf_warp_fifo
  import gpu_ib_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  ib_entry_t                enq_data,
  input  logic                     deq,
  input  logic                     flush,
  output ib_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ib_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              full_q,   full_d;
  logic              empty_q,  empty_d;
  logic              do_enq;
  logic              do_deq;

  assign do_enq = enq & ~flush;
  assign do_deq = deq & ~empty_q & ~flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_enq) - CW'(do_deq);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: payload storage has no reset; validity is tracked by count, so stale data is never issued.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr_q] <= enq_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ibuffer_warp.sv
// Per-warp instruction buffer: arbitrates the two decode lanes into eight warp
// FIFOs, muxes the granted warp's head to issue and tracks dropped enqueues.
module ibuffer_warp
  import gpu_ib_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [NUM_WARPS-1:0] Valid_2_ID0_IB,
  input  logic [31:0]          Inst_ID0_IB,
  input  logic [4:0]           Src1_ID0_IB,
  input  logic [4:0]           Src2_ID0_IB,
  input  logic [4:0]           Dst_ID0_IB,
  input  logic [15:0]          Imme_ID0_IB,
  input  logic                 RegWrite_ID0_IB,
  input  logic                 MemWrite_ID0_IB,
  input  logic                 MemRead_ID0_IB,
  input  logic                 Exit_ID0_IB,
  input  logic [3:0]           ALUop_ID0_IB,
  input  logic                 Shared_Globalbar_ID0_IB,
  input  logic                 Src1_Valid_ID0_IB,
  input  logic                 Src2_Valid_ID0_IB,
  input  logic                 Imme_Valid_ID0_IB,
  input  logic                 BEQ_ID0_IB,
  input  logic                 BLT_ID0_IB,

  input  logic [NUM_WARPS-1:0] Valid_2_ID1_IB,
  input  logic [31:0]          Inst_ID1_IB,
  input  logic [4:0]           Src1_ID1_IB,
  input  logic [4:0]           Src2_ID1_IB,
  input  logic [4:0]           Dst_ID1_IB,
  input  logic [15:0]          Imme_ID1_IB,
  input  logic                 RegWrite_ID1_IB,
  input  logic                 MemWrite_ID1_IB,
  input  logic                 MemRead_ID1_IB,
  input  logic                 Exit_ID1_IB,
  input  logic [3:0]           ALUop_ID1_IB,
  input  logic                 Shared_Globalbar_ID1_IB,
  input  logic                 Src1_Valid_ID1_IB,
  input  logic                 Src2_Valid_ID1_IB,
  input  logic                 Imme_Valid_ID1_IB,
  input  logic                 BEQ_ID1_IB,
  input  logic                 BLT_ID1_IB,

  input  logic [NUM_WARPS-1:0] Flush_SIMT_IB,
  input  logic [NUM_WARPS-1:0] Grant_ISS_IB,

  output logic [NUM_WARPS-1:0] Ready_IB_ISS,
  output logic                 Issue_Valid_IB_ISS,
  output logic [31:0]          Inst_IB_ISS,
  output logic [4:0]           Src1_IB_ISS,
  output logic [4:0]           Src2_IB_ISS,
  output logic [4:0]           Dst_IB_ISS,
  output logic [15:0]          Imme_IB_ISS,
  output logic                 RegWrite_IB_ISS,
  output logic                 MemWrite_IB_ISS,
  output logic                 MemRead_IB_ISS,
  output logic                 Exit_IB_ISS,
  output logic [3:0]           ALUop_IB_ISS,
  output logic                 Shared_Globalbar_IB_ISS,
  output logic                 Src1_Valid_IB_ISS,
  output logic                 Src2_Valid_IB_ISS,
  output logic                 Imme_Valid_IB_ISS,
  output logic                 BEQ_IB_ISS,
  output logic                 BLT_IB_ISS,

  output logic [NUM_WARPS-1:0] Full_IB_PC,
  output logic                 Overflow_IB
);

  localparam int CW = $clog2(DEPTH) + 1;

  ib_entry_t             lane0, lane1;
  ib_entry_t             warp_enq_data [NUM_WARPS];
  ib_entry_t             warp_head     [NUM_WARPS];
  logic [CW-1:0]         warp_count    [NUM_WARPS];
  logic [NUM_WARPS-1:0]  warp_enq;
  logic [NUM_WARPS-1:0]  warp_deq;
  logic [NUM_WARPS-1:0]  warp_full;
  logic [NUM_WARPS-1:0]  warp_empty;
  logic [NUM_WARPS-1:0]  ready;
  logic                  drop_any;
  logic                  overflow_q, overflow_d;
  ib_entry_t             head_sel;

  assign lane0 = '{Inst: Inst_ID0_IB, Src1: Src1_ID0_IB, Src2: Src2_ID0_IB,
                   Dst: Dst_ID0_IB, Imme: Imme_ID0_IB, RegWrite: RegWrite_ID0_IB,
                   MemWrite: MemWrite_ID0_IB, MemRead: MemRead_ID0_IB,
                   Exit: Exit_ID0_IB, ALUop: ALUop_ID0_IB,
                   Shared_Globalbar: Shared_Globalbar_ID0_IB,
                   Src1_Valid: Src1_Valid_ID0_IB, Src2_Valid: Src2_Valid_ID0_IB,
                   Imme_Valid: Imme_Valid_ID0_IB, BEQ: BEQ_ID0_IB, BLT: BLT_ID0_IB};

  assign lane1 = '{Inst: Inst_ID1_IB, Src1: Src1_ID1_IB, Src2: Src2_ID1_IB,
                   Dst: Dst_ID1_IB, Imme: Imme_ID1_IB, RegWrite: RegWrite_ID1_IB,
                   MemWrite: MemWrite_ID1_IB, MemRead: MemRead_ID1_IB,
                   Exit: Exit_ID1_IB, ALUop: ALUop_ID1_IB,
                   Shared_Globalbar: Shared_Globalbar_ID1_IB,
                   Src1_Valid: Src1_Valid_ID1_IB, Src2_Valid: Src2_Valid_ID1_IB,
                   Imme_Valid: Imme_Valid_ID1_IB, BEQ: BEQ_ID1_IB, BLT: BLT_ID1_IB};

  assign ready    = ~warp_empty;
  assign warp_deq = Grant_ISS_IB & ready;

  // Lane arbitration and space check; a flushed warp discards silently.
  always_comb begin
    drop_any = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_enq[w]      = 1'b0;
      warp_enq_data[w] = lane0;
      if (!Flush_SIMT_IB[w] && (Valid_2_ID0_IB[w] || Valid_2_ID1_IB[w])) begin
        warp_enq_data[w] = Valid_2_ID0_IB[w] ? lane0 : lane1;
        if ((warp_count[w] < CW'(DEPTH)) ||
            ((warp_count[w] == CW'(DEPTH)) && warp_deq[w])) begin
          warp_enq[w] = 1'b1;
        end else begin
          drop_any = 1'b1;
        end
        if (Valid_2_ID0_IB[w] && Valid_2_ID1_IB[w]) drop_any = 1'b1;
      end
    end
    overflow_d = overflow_q | drop_any;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    ibuf_warp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .enq      (warp_enq[g]),
      .enq_data (warp_enq_data[g]),
      .deq      (warp_deq[g]),
      .flush    (Flush_SIMT_IB[g]),
      .head     (warp_head[g]),
      .count    (warp_count[g]),
      .full     (warp_full[g]),
      .empty    (warp_empty[g])
    );
  end

  // AND-OR grant mux: an ungranted or empty warp contributes zero.
  always_comb begin
    head_sel = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (warp_deq[w]) head_sel = ib_entry_t'(head_sel | warp_head[w]);
    end
  end

  assign Ready_IB_ISS            = ready;
  assign Full_IB_PC              = warp_full;
  assign Overflow_IB             = overflow_q;
  assign Issue_Valid_IB_ISS      = |warp_deq;

  assign Inst_IB_ISS             = head_sel.Inst;
  assign Src1_IB_ISS             = head_sel.Src1;
  assign Src2_IB_ISS             = head_sel.Src2;
  assign Dst_IB_ISS              = head_sel.Dst;
  assign Imme_IB_ISS             = head_sel.Imme;
  assign RegWrite_IB_ISS         = head_sel.RegWrite;
  assign MemWrite_IB_ISS         = head_sel.MemWrite;
  assign MemRead_IB_ISS          = head_sel.MemRead;
  assign Exit_IB_ISS             = head_sel.Exit;
  assign ALUop_IB_ISS            = head_sel.ALUop;
  assign Shared_Globalbar_IB_ISS = head_sel.Shared_Globalbar;
  assign Src1_Valid_IB_ISS       = head_sel.Src1_Valid;
  assign Src2_Valid_IB_ISS       = head_sel.Src2_Valid;
  assign Imme_Valid_IB_ISS       = head_sel.Imme_Valid;
  assign BEQ_IB_ISS              = head_sel.BEQ;
  assign BLT_IB_ISS              = head_sel.BLT;

endmodule

// File: tb/tb_ibuffer_warp.sv
// Scoreboard bench for ibuffer_warp: per-warp queues of expected entries are
// filled as lanes are driven and popped when the bench grants a warp.
module tb_ibuffer_warp;
  import gpu_ib_pkg::*;

  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_WARPS-1:0] v0 = '0, v1 = '0, grant = '0, flush = '0;
  ib_entry_t            e0 = '0, e1 = '0;

  logic [NUM_WARPS-1:0] ready_o, full_o;
  logic                 iv_o, ovf_o;
  logic [31:0]          inst_o;
  logic [4:0]           src1_o, src2_o, dst_o;
  logic [15:0]          imme_o;
  logic                 regw_o, memw_o, memr_o, exit_o;
  logic [3:0]           aluop_o;
  logic                 sg_o, s1v_o, s2v_o, imv_o, beq_o, blt_o;
  ib_entry_t            head_o;

  assign head_o = {inst_o, src1_o, src2_o, dst_o, imme_o, regw_o, memw_o, memr_o,
                   exit_o, aluop_o, sg_o, s1v_o, s2v_o, imv_o, beq_o, blt_o};

  always #5 clk = ~clk;

  ibuffer_warp #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .Valid_2_ID0_IB(v0), .Inst_ID0_IB(e0.Inst), .Src1_ID0_IB(e0.Src1),
    .Src2_ID0_IB(e0.Src2), .Dst_ID0_IB(e0.Dst), .Imme_ID0_IB(e0.Imme),
    .RegWrite_ID0_IB(e0.RegWrite), .MemWrite_ID0_IB(e0.MemWrite),
    .MemRead_ID0_IB(e0.MemRead), .Exit_ID0_IB(e0.Exit), .ALUop_ID0_IB(e0.ALUop),
    .Shared_Globalbar_ID0_IB(e0.Shared_Globalbar), .Src1_Valid_ID0_IB(e0.Src1_Valid),
    .Src2_Valid_ID0_IB(e0.Src2_Valid), .Imme_Valid_ID0_IB(e0.Imme_Valid),
    .BEQ_ID0_IB(e0.BEQ), .BLT_ID0_IB(e0.BLT),
    .Valid_2_ID1_IB(v1), .Inst_ID1_IB(e1.Inst), .Src1_ID1_IB(e1.Src1),
    .Src2_ID1_IB(e1.Src2), .Dst_ID1_IB(e1.Dst), .Imme_ID1_IB(e1.Imme),
    .RegWrite_ID1_IB(e1.RegWrite), .MemWrite_ID1_IB(e1.MemWrite),
    .MemRead_ID1_IB(e1.MemRead), .Exit_ID1_IB(e1.Exit), .ALUop_ID1_IB(e1.ALUop),
    .Shared_Globalbar_ID1_IB(e1.Shared_Globalbar), .Src1_Valid_ID1_IB(e1.Src1_Valid),
    .Src2_Valid_ID1_IB(e1.Src2_Valid), .Imme_Valid_ID1_IB(e1.Imme_Valid),
    .BEQ_ID1_IB(e1.BEQ), .BLT_ID1_IB(e1.BLT),
    .Flush_SIMT_IB(flush), .Grant_ISS_IB(grant),
    .Ready_IB_ISS(ready_o), .Issue_Valid_IB_ISS(iv_o),
    .Inst_IB_ISS(inst_o), .Src1_IB_ISS(src1_o), .Src2_IB_ISS(src2_o),
    .Dst_IB_ISS(dst_o), .Imme_IB_ISS(imme_o), .RegWrite_IB_ISS(regw_o),
    .MemWrite_IB_ISS(memw_o), .MemRead_IB_ISS(memr_o), .Exit_IB_ISS(exit_o),
    .ALUop_IB_ISS(aluop_o), .Shared_Globalbar_IB_ISS(sg_o),
    .Src1_Valid_IB_ISS(s1v_o), .Src2_Valid_IB_ISS(s2v_o),
    .Imme_Valid_IB_ISS(imv_o), .BEQ_IB_ISS(beq_o), .BLT_IB_ISS(blt_o),
    .Full_IB_PC(full_o), .Overflow_IB(ovf_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: one queue of expected entries per warp plus the sticky flag.
  ib_entry_t mq [NUM_WARPS][$];
  logic      m_ovf = 1'b0;

  function automatic ib_entry_t rand_entry();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return ib_entry_t'(r[ENTRY_W-1:0]);
  endfunction

  function automatic ib_entry_t inst_entry(input logic [31:0] inst);
    ib_entry_t e;
    e = rand_entry();
    e.Inst = inst;
    return e;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic r, input logic [7:0] a0, input ib_entry_t d0,
                      input logic [7:0] a1, input ib_entry_t d1,
                      input logic [7:0] g, input logic [7:0] f);
    logic [7:0] exp_ready, exp_full;
    ib_entry_t  exp_head;
    @(negedge clk);
    rst = r; v0 = a0; e0 = d0; v1 = a1; e1 = d1; grant = g; flush = f;
    #1;
    exp_ready = '0; exp_full = '0; exp_head = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      exp_ready[w] = (mq[w].size() != 0);
      exp_full[w]  = (mq[w].size() == DEPTH);
      if (g[w] && mq[w].size() != 0) exp_head = ib_entry_t'(exp_head | mq[w][0]);
    end
    check("ready", ready_o, exp_ready);
    check("full", full_o, exp_full);
    check("overflow", ovf_o, m_ovf);
    check("issue_valid", iv_o, |(g & exp_ready));
    check("head", head_o, exp_head);
    if (r) begin
      for (int w = 0; w < NUM_WARPS; w++) mq[w].delete();
      m_ovf = 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (f[w]) begin
          mq[w].delete();
        end else begin
          if (g[w] && mq[w].size() != 0) void'(mq[w].pop_front());
          if (a0[w] || a1[w]) begin
            if (a0[w] && a1[w]) m_ovf = 1'b1;
            if (mq[w].size() < DEPTH) mq[w].push_back(a0[w] ? d0 : d1);
            else m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic idle(input logic [7:0] g);
    step(1'b0, 8'h00, '0, 8'h00, '0, g, 8'h00);
  endtask

  initial begin
    logic [7:0] a0, a1, g, f;

    step(1'b1, 8'h00, '0, 8'h00, '0, 8'h00, 8'h00);
    step(1'b1, 8'h00, '0, 8'h00, '0, 8'h00, 8'h00);

    // Single enqueue then issue of a known instruction.
    step(1'b0, 8'h01, inst_entry(32'h0022_1820), 8'h00, '0, 8'h00, 8'h00);
    idle(8'h00);
    idle(8'h01);
    idle(8'h00);

    // Two lanes to two different warps in one cycle.
    step(1'b0, 8'h04, rand_entry(), 8'h80, rand_entry(), 8'h00, 8'h00);
    idle(8'h00);
    idle(8'h80);
    idle(8'h04);
    idle(8'h00);

    // Fill warp 2 past DEPTH; third enqueue is dropped.
    step(1'b0, 8'h04, inst_entry(32'h1), 8'h00, '0, 8'h00, 8'h00);
    step(1'b0, 8'h04, inst_entry(32'h2), 8'h00, '0, 8'h00, 8'h00);
    step(1'b0, 8'h04, inst_entry(32'hDEAD), 8'h00, '0, 8'h00, 8'h00);
    idle(8'h00);

    // Full warp: dequeue plus enqueue in the same cycle, then drain with wrap.
    step(1'b0, 8'h04, inst_entry(32'h3), 8'h00, '0, 8'h04, 8'h00);
    idle(8'h04);
    step(1'b0, 8'h04, inst_entry(32'h4), 8'h00, '0, 8'h04, 8'h00);
    idle(8'h04);
    idle(8'h04);
    idle(8'h04);
    idle(8'h00);

    // Flush beats a same-cycle enqueue without flagging overflow.
    step(1'b1, 8'h00, '0, 8'h00, '0, 8'h00, 8'h00);
    step(1'b0, 8'h20, rand_entry(), 8'h00, '0, 8'h00, 8'h00);
    step(1'b0, 8'h20, rand_entry(), 8'h00, '0, 8'h00, 8'h20);
    idle(8'h20);
    idle(8'h00);

    // Lane collision on warp 4, then reset clears everything.
    step(1'b0, 8'h10, rand_entry(), 8'h10, rand_entry(), 8'h00, 8'h00);
    idle(8'h00);
    step(1'b0, 8'h01, rand_entry(), 8'h02, rand_entry(), 8'h00, 8'h00);
    step(1'b0, 8'h01, rand_entry(), 8'h02, rand_entry(), 8'h00, 8'h00);
    step(1'b1, 8'h00, '0, 8'h00, '0, 8'h00, 8'h00);
    idle(8'h00);
    idle(8'h10);

    // Random mixed traffic, including multi-hot tags and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      a0 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a0 = a0 | 8'(1 << $urandom_range(0, 7));
      g  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      f  = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      step(1'b0, a0, rand_entry(), a1, rand_entry(), g, f);
      if (i == 200) step(1'b1, 8'h00, '0, 8'h00, '0, 8'h00, 8'h00);
    end
    idle(8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ibuffer_warp.md
# ibuffer_warp

Per-warp instruction buffer: the receiving end of the dual-lane Decode → I-buffer interface. Accepts up to two decoded instructions per cycle (lanes ID0/ID1), each tagged by a one-hot warp mask, and holds them in an in-order FIFO per warp (8 warps). It presents each warp's head to the issue scheduler, dequeues on a one-hot grant, and returns per-warp full status to fetch. Per-warp flush comes from the SIMT stack.

## Interface
- DEPTH, 2, entries per warp FIFO; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- Valid_2_ID{0,1}_IB  in  8  one-hot warp tag per lane; zero means lane idle.
- Inst/Src1/Src2/Dst/Imme_ID{0,1}_IB  in  32/5/5/5/16  decoded fields per lane.
- RegWrite/MemWrite/MemRead/Exit/Shared_Globalbar/Src1_Valid/Src2_Valid/Imme_Valid/BEQ/BLT_ID{0,1}_IB  in  1 each  control flags per lane.
- ALUop_ID{0,1}_IB  in  4  ALU opcode per lane.
- Flush_SIMT_IB  in  8  per-warp flush mask.
- Grant_ISS_IB  in  8  one-hot issue grant.
- Ready_IB_ISS  out  8  warp FIFO non-empty.
- Issue_Valid_IB_ISS  out  1  |(Grant_ISS_IB & Ready_IB_ISS).
- *_IB_ISS  out  same widths as lane fields  head entry of granted warp.
- Full_IB_PC  out  8  warp FIFO holds DEPTH entries.
- Overflow_IB  out  1  sticky: an enqueue was dropped.

## Operation
- Entry = all lane payload fields packed (77 bits); stored verbatim.
- Enqueue: for each warp w, lane L writes if Valid_2_IDL_IB[w]. Multi-hot tags write into every tagged warp.
- Both lanes tagging the same warp in one cycle: ID0 enqueued, ID1 dropped, Overflow_IB set.
- Space rule: enqueue accepted if count[w] < DEPTH, or count[w] == DEPTH and the warp is dequeued that cycle. Otherwise dropped, Overflow_IB set.
- Dequeue: warp w pops when Grant_ISS_IB[w] & Ready_IB_ISS[w]. Grant on an empty warp has no effect.
- Head output: OR over w of (Grant[w] & Ready[w] ? head[w] : 0). The output is all-zero when nothing is granted.
- Flush_SIMT_IB[w] clears warp w (rd_ptr=wr_ptr=0, count=0). Flush wins over same-cycle enqueue and dequeue for that warp: the enqueue is discarded with no overflow flag.
- Per-warp state: wr_ptr and rd_ptr (log2 DEPTH bits each, wrap modulo DEPTH), count (log2 DEPTH + 1 bits). Each warp is independent of the others.
- Overflow_IB clears only on rst.

## Timing
- Reset (rst high at edge): all counts and pointers 0. Ready_IB_ISS=0, Full_IB_PC=0, Overflow_IB=0. Payload storage is not cleared.
- Ready_IB_ISS and Full_IB_PC are registered, derived from count. An enqueue at edge t is visible as Ready in cycle t+1, giving a 1-cycle decode-to-issue minimum.
- Head payload and Issue_Valid_IB_ISS are combinational from Grant and registered state. No pipeline register sits on the issue path.
- Dequeue at edge t exposes the next entry (or Ready=0) in cycle t+1.
- Simultaneous enqueue and dequeue on the same warp: count unchanged, both pointers advance.
- Fetch must stop a warp when Full_IB_PC is high. The IF→ID skid is not absorbed, so excess entries are dropped and flagged.
- rst mid-operation discards all buffered entries on that edge.

## Structure
- Package gpu_ib_pkg holds: ib_entry_t packed struct (field order Inst, Src1, Src2, Dst, Imme, RegWrite, MemWrite, MemRead, Exit, ALUop, Shared_Globalbar, Src1_Valid, Src2_Valid, Imme_Valid, BEQ, BLT), NUM_WARPS=8, and ALUop constants.
- Sub-module ibuf_warp_fifo, one instance per warp. Ports: enq, enq_data, deq, flush, head, count, full, empty. The top level handles lane arbitration, the grant mux and the overflow flag.

## Test plan
- After reset, ID0 tag 8'h01 with Inst 32'h0022_1820 → Ready=8'h01 next cycle. Grant 8'h01 → Inst_IB_ISS=32'h0022_1820, Issue_Valid=1. Ready=0 the cycle after.
- ID0 tag 8'h04 and ID1 tag 8'h80 in the same cycle → Ready=8'h84. Grants 8'h80 then 8'h04 return the matching payloads.
- Three enqueues to warp 2 with DEPTH=2 and no grant → Full=8'h04 after the second. The third is dropped and Overflow_IB=1. Head is still the first instruction.
- Warp 2 full, grant 8'h04 plus a new enqueue in the same cycle → count stays 2. Pops return entries in order 2, 3; pointers wrap correctly.
- Warp 5 holds 1 entry; Flush 8'h20 plus an ID0 enqueue to warp 5 in the same cycle → Ready[5]=0 and Overflow_IB stays 0.
- Both lanes tag 8'h10 → one entry (the ID0 payload) and Overflow_IB=1. Asserting rst clears Ready, Full and Overflow on the next edge.
